// File: rtl/countdown_timer.sv
// Minutes/seconds countdown timer: loads a clamped start time, decrements on
// each tick while running, and flags expiry with a done pulse and held alarm.
module countdown_timer #(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [6:0] min_in,
    input  logic [6:0] sec_in,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] min_out,
    output logic [6:0] sec_out,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam logic [6:0] SEC_MAX_7 = 7'(SEC_MAX);
    localparam logic [6:0] MIN_MAX_7 = 7'(MIN_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state_r;
    logic [6:0] min_r;
    logic [6:0] sec_r;
    logic       running_r;
    logic       done_r;
    logic       alarm_r;
    logic       count_zero_s;

    function automatic logic [6:0] clamp7(input logic [6:0] value, input logic [6:0] limit);
        return (value > limit) ? limit : value;
    endfunction

    // Zero detect gates start requests so a 0:00 count never enters RUN.
    always_comb begin
        count_zero_s = (min_r == 7'd0) && (sec_r == 7'd0);
    end

    // Timer state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            min_r     <= 7'd0;
            sec_r     <= 7'd0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            alarm_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, PAUSED: begin
                    if (load) begin
                        min_r     <= clamp7(min_in, MIN_MAX_7);
                        sec_r     <= clamp7(sec_in, SEC_MAX_7);
                        alarm_r   <= 1'b0;
                        running_r <= 1'b0;
                        state_r   <= IDLE;
                    end else if (start && !pause && !count_zero_s) begin
                        running_r <= 1'b1;
                        state_r   <= RUN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                RUN: begin
                    // Load is ignored here, so pause and tick see it as absent.
                    if (pause) begin
                        running_r <= 1'b0;
                        state_r   <= PAUSED;
                    end else if (tick) begin
                        if (sec_r != 7'd0) begin
                            sec_r <= sec_r - 7'd1;
                            if ((min_r == 7'd0) && (sec_r == 7'd1)) begin
                                done_r    <= 1'b1;
                                alarm_r   <= 1'b1;
                                running_r <= 1'b0;
                                state_r   <= EXPIRED;
                            end else begin
                                state_r <= RUN;
                            end
                        end else if (min_r != 7'd0) begin
                            min_r <= min_r - 7'd1;
                            sec_r <= SEC_MAX_7;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                EXPIRED: begin
                    if (load) begin
                        min_r     <= clamp7(min_in, MIN_MAX_7);
                        sec_r     <= clamp7(sec_in, SEC_MAX_7);
                        alarm_r   <= 1'b0;
                        running_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= EXPIRED;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign min_out = min_r;
    assign sec_out = sec_r;
    assign running = running_r;
    assign done    = done_r;
    assign alarm   = alarm_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer with hand-computed expected values.
module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       load;
    logic [6:0] min_in;
    logic [6:0] sec_in;
    logic       start;
    logic       pause;
    logic [6:0] min_out;
    logic [6:0] sec_out;
    logic       running;
    logic       done;
    logic       alarm;

    int passed = 0;
    int total  = 0;

    countdown_timer dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .load    (load),
        .min_in  (min_in),
        .sec_in  (sec_in),
        .start   (start),
        .pause   (pause),
        .min_out (min_out),
        .sec_out (sec_out),
        .running (running),
        .done    (done),
        .alarm   (alarm)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Expected count and status flags after the most recent edge.
    task automatic check_all(input string tag, input logic [6:0] m, input logic [6:0] s,
                             input logic r, input logic d, input logic a);
        check({tag, ".min"}, min_out, m);
        check({tag, ".sec"}, sec_out, s);
        check({tag, ".running"}, {6'd0, running}, {6'd0, r});
        check({tag, ".done"}, {6'd0, done}, {6'd0, d});
        check({tag, ".alarm"}, {6'd0, alarm}, {6'd0, a});
    endtask

    // Apply one cycle of inputs, advance past the edge, then release them.
    task automatic cyc(input logic t, input logic l, input logic st, input logic p,
                       input logic [6:0] m, input logic [6:0] s);
        tick = t; load = l; start = st; pause = p; min_in = m; sec_in = s;
        @(posedge clk);
        #1;
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
        min_in = 7'd0; sec_in = 7'd0;
        @(posedge clk); #1;
        check_all("rst1", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_all("rst2", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; tick = 1'b0;

        // Borrow from minutes.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 7'd2);
        check_all("load102", 7'd1, 7'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
        check_all("start102", 7'd1, 7'd2, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("t101", 7'd1, 7'd1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("t100", 7'd1, 7'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("t059", 7'd0, 7'd59, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 7'd0);
        check_all("pause059", 7'd0, 7'd59, 1'b0, 1'b0, 1'b0);

        // Expiry, done pulse, held alarm.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd2);
        check_all("load002", 7'd0, 7'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
        check_all("start002", 7'd0, 7'd2, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("t001", 7'd0, 7'd1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("expire", 7'd0, 7'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("after_done", 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("exp_tick", 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
        check_all("exp_start", 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);

        // Load out of EXPIRED clears alarm; clamping; start at 0:00 ignored.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd5);
        check_all("load005", 7'd0, 7'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd120, 7'd75);
        check_all("clamp", 7'd99, 7'd59, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("load000", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
        check_all("start000", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // Pause drops a same-cycle tick; load in RUN ignored; resume.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd10);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
        check_all("start010", 7'd0, 7'd10, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("t007", 7'd0, 7'd7, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 7'd0);
        check_all("pause_tick", 7'd0, 7'd7, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("paused_tick", 7'd0, 7'd7, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 7'd0);
        check_all("paused_both", 7'd0, 7'd7, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
        check_all("resume", 7'd0, 7'd7, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd5, 7'd5);
        check_all("run_load", 7'd0, 7'd7, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 7'd5, 7'd5);
        check_all("run_load_tick", 7'd0, 7'd6, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 7'd0, 7'd0);
        check_all("run_both", 7'd0, 7'd6, 1'b0, 1'b0, 1'b0);

        // Reset mid-run at 0:03 overrides tick, load and start.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd4);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        check_all("t003", 7'd0, 7'd3, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 7'd9, 7'd9);
        reset = 1'b0;
        check_all("mid_reset", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
        check_all("post_reset_start", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
